// File: rtl/maxil_read_top.sv
// AXI4-Lite master read engine: one command in, one AR/R transaction out,
// one response back. A single transaction is outstanding at a time.
// Optional R-phase watchdog with flush of the late beat: MAXIL_READ_TIMEOUT_EN.
module maxil_read_top #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  maxil_read_top_clk,
   input  logic                  maxil_read_top_rst_n,
   input  logic                  maxil_read_cmd_valid,
   output logic                  maxil_read_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] maxil_read_cmd_addr,
   input  logic [2:0]            maxil_read_cmd_prot,
   output logic                  maxil_read_arvalid,
   input  logic                  maxil_read_arready,
   output logic [ADDR_WIDTH-1:0] maxil_read_araddr,
   output logic [2:0]            maxil_read_arprot,
   input  logic                  maxil_read_rvalid,
   output logic                  maxil_read_rready,
   input  logic [DATA_WIDTH-1:0] maxil_read_rdata,
   input  logic [1:0]            maxil_read_rresp,
   output logic                  maxil_read_rsp_valid,
   input  logic                  maxil_read_rsp_ready,
   output logic [DATA_WIDTH-1:0] maxil_read_rsp_data,
   output logic [1:0]            maxil_read_rsp_resp,
   output logic                  maxil_read_rsp_timeout
);

   // The watchdog needs at least one beat-less cycle before its terminal count.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
      $error("maxil_read_top: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

   state_t                  state_q, state_d;
   logic                    arvalid_d;
   logic [ADDR_WIDTH-1:0]   araddr_d;
   logic [2:0]              arprot_d;
   logic                    rready_d;
   logic                    rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_d;
   logic [1:0]              rsp_resp_d;

`ifdef MAXIL_READ_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_q, flush_d;
   logic             timeout_d;

   // A command may only start once any abandoned R beat has been drained.
   assign maxil_read_cmd_ready = (state_q == IDLE) && !flush_q;
`else
   assign maxil_read_cmd_ready   = (state_q == IDLE);
   assign maxil_read_rsp_timeout = 1'b0;
`endif

   // State and registered AXI / response outputs.
   always_ff @(posedge maxil_read_top_clk or negedge maxil_read_top_rst_n) begin
      if (!maxil_read_top_rst_n) begin
         state_q              <= IDLE;
         maxil_read_arvalid   <= 1'b0;
         maxil_read_araddr    <= '0;
         maxil_read_arprot    <= '0;
         maxil_read_rready    <= 1'b0;
         maxil_read_rsp_valid <= 1'b0;
         maxil_read_rsp_data  <= '0;
         maxil_read_rsp_resp  <= '0;
      end else begin
         state_q              <= state_d;
         maxil_read_arvalid   <= arvalid_d;
         maxil_read_araddr    <= araddr_d;
         maxil_read_arprot    <= arprot_d;
         maxil_read_rready    <= rready_d;
         maxil_read_rsp_valid <= rsp_valid_d;
         maxil_read_rsp_data  <= rsp_data_d;
         maxil_read_rsp_resp  <= rsp_resp_d;
      end
   end

`ifdef MAXIL_READ_TIMEOUT_EN
   // Watchdog counter, flush flag and timeout indication.
   always_ff @(posedge maxil_read_top_clk or negedge maxil_read_top_rst_n) begin
      if (!maxil_read_top_rst_n) begin
         cnt_q                  <= '0;
         flush_q                <= 1'b0;
         maxil_read_rsp_timeout <= 1'b0;
      end else begin
         cnt_q                  <= cnt_d;
         flush_q                <= flush_d;
         maxil_read_rsp_timeout <= timeout_d;
      end
   end
`endif

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_d     = state_q;
      arvalid_d   = maxil_read_arvalid;
      araddr_d    = maxil_read_araddr;
      arprot_d    = maxil_read_arprot;
      rready_d    = maxil_read_rready;
      rsp_valid_d = maxil_read_rsp_valid;
      rsp_data_d  = maxil_read_rsp_data;
      rsp_resp_d  = maxil_read_rsp_resp;
`ifdef MAXIL_READ_TIMEOUT_EN
      cnt_d       = cnt_q;
      flush_d     = flush_q;
      timeout_d   = maxil_read_rsp_timeout;
`endif
      case (state_q)
         IDLE: begin
            if (maxil_read_cmd_valid && maxil_read_cmd_ready) begin
               araddr_d  = maxil_read_cmd_addr;
               arprot_d  = maxil_read_cmd_prot;
               arvalid_d = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (maxil_read_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = DATA;
`ifdef MAXIL_READ_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         DATA: begin
            if (maxil_read_rvalid) begin
               rsp_data_d  = maxil_read_rdata;
               rsp_resp_d  = maxil_read_rresp;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
`ifdef MAXIL_READ_TIMEOUT_EN
               timeout_d   = 1'b0;
`endif
            end
`ifdef MAXIL_READ_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               rsp_data_d  = '0;
               rsp_resp_d  = 2'b10;
               timeout_d   = 1'b1;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               flush_d     = 1'b1;
               state_d     = RSP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RSP: begin
            if (maxil_read_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef MAXIL_READ_TIMEOUT_EN
      // After a timeout, keep rready up outside the transaction to swallow the late beat.
      if ((state_q == IDLE) || (state_q == RSP)) begin
         if (flush_q && maxil_read_rready && maxil_read_rvalid) begin
            flush_d  = 1'b0;
            rready_d = 1'b0;
         end else begin
            rready_d = flush_q;
         end
      end
`endif
   end

endmodule

// File: tb/tb_maxil_read_top.sv
// Self-checking bench for maxil_read_top with a randomized slave/consumer
// and a behavioural model of the expected response and latency.
module tb_maxil_read_top;

   localparam int TO = 8;
`ifdef MAXIL_READ_TIMEOUT_EN
   localparam int R_MAX = TO - 1;
`else
   localparam int R_MAX = 12;
`endif

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_prot;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;

   int          n_checks;
   int          n_pass;
   int          cyc_count;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        to;
      int          lat;
      int          ar_cyc;
      int          hs_c;
      bit          ar_bad;
      bit          rr_bad;
      bit          rsp_bad;
      bit          busy_ready;
      bit          timed_out;
   } res_t;

   maxil_read_top #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .maxil_read_top_clk    (clk),
      .maxil_read_top_rst_n  (rst_n),
      .maxil_read_cmd_valid  (cmd_valid),
      .maxil_read_cmd_ready  (cmd_ready),
      .maxil_read_cmd_addr   (cmd_addr),
      .maxil_read_cmd_prot   (cmd_prot),
      .maxil_read_arvalid    (arvalid),
      .maxil_read_arready    (arready),
      .maxil_read_araddr     (araddr),
      .maxil_read_arprot     (arprot),
      .maxil_read_rvalid     (rvalid),
      .maxil_read_rready     (rready),
      .maxil_read_rdata      (rdata),
      .maxil_read_rresp      (rresp),
      .maxil_read_rsp_valid  (rsp_valid),
      .maxil_read_rsp_ready  (rsp_ready),
      .maxil_read_rsp_data   (rsp_data),
      .maxil_read_rsp_resp   (rsp_resp),
      .maxil_read_rsp_timeout(rsp_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_count <= cyc_count + 1;

   // Expected response: the slave beat arrives in DATA cycle r_wait (0-based);
   // with the watchdog, no beat within TO DATA cycles yields a SLVERR timeout.
   function automatic void model(input logic [31:0] data, input logic [1:0] resp,
                                 input int ar_wait, input int r_wait,
                                 output logic [31:0] e_data, output logic [1:0] e_resp,
                                 output logic e_to, output int e_lat);
      e_data = data;
      e_resp = resp;
      e_to   = 1'b0;
      e_lat  = 3 + ar_wait + r_wait;
`ifdef MAXIL_READ_TIMEOUT_EN
      if (r_wait >= TO) begin
         e_data = 32'h0;
         e_resp = 2'b10;
         e_to   = 1'b1;
         e_lat  = 2 + ar_wait + TO;
      end
`endif
   endfunction

   // Plays slave and consumer for one command; records what the DUT did.
   task automatic run_read(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int ar_wait, input int r_wait, input int rsp_wait,
                           input bit noise, output res_t r);
      int guard;
      int cyc;
      int r_cnt;
      int rsp_cnt;
      int phase;
      bit done;
      r.data = '0; r.resp = '0; r.to = 1'b0; r.lat = 0; r.ar_cyc = 0; r.hs_c = 0;
      r.ar_bad = 0; r.rr_bad = 0; r.rsp_bad = 0; r.busy_ready = 0; r.timed_out = 0;
      guard = 0;
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) r.timed_out = 1;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_prot  = prot;
      @(posedge clk);
      @(negedge clk);
      r.hs_c  = cyc_count;
      cyc     = 1;
      r_cnt   = 0;
      rsp_cnt = 0;
      phase   = 0;
      done    = 0;
      while (!done && cyc <= 2000) begin
         cmd_valid = noise ? 1'($urandom) : 1'b0;
         cmd_addr  = $urandom;
         cmd_prot  = 3'($urandom);
         arready   = 1'b0;
         rvalid    = 1'b0;
         rsp_ready = 1'b0;
         rdata     = $urandom;
         rresp     = 2'($urandom);
         if (cmd_ready) r.busy_ready = 1;
         if (rsp_valid) begin
            if (rsp_cnt == 0) begin
               r.lat  = cyc;
               r.data = rsp_data;
               r.resp = rsp_resp;
               r.to   = rsp_timeout;
            end else if (rsp_data !== r.data || rsp_resp !== r.resp || rsp_timeout !== r.to) begin
               r.rsp_bad = 1;
            end
            rsp_cnt++;
            if (rsp_cnt > rsp_wait) begin
               rsp_ready = 1'b1;
               cmd_valid = 1'b0;
               done      = 1;
            end
         end else if (phase == 0) begin
            if (rready) r.rr_bad = 1;
            if (noise) rvalid = 1'($urandom);
            if (!arvalid) begin
               r.ar_bad = 1;
            end else begin
               r.ar_cyc++;
               if (araddr !== addr || arprot !== prot) r.ar_bad = 1;
               if (r.ar_cyc > ar_wait) begin
                  arready = 1'b1;
                  phase   = 1;
               end
            end
         end else begin
            if (arvalid || !rready) r.rr_bad = 1;
            r_cnt++;
            if (r_cnt > r_wait) begin
               rvalid = 1'b1;
               rdata  = data;
               rresp  = resp;
            end
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (done) begin
         @(posedge clk);
         @(negedge clk);
      end else begin
         r.timed_out = 1;
      end
      cmd_valid = 1'b0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_checks++;
      if ({arvalid, rready, rsp_valid} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {arvalid, rready, rsp_valid});
      else n_pass++;
      n_checks++;
      if (araddr !== 32'h0) $display("FAIL reset_araddr: got %h expected 00000000", araddr);
      else n_pass++;
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      else n_pass++;
      #9 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready);
      else n_pass++;
      n_checks++;
      if ({rsp_timeout, rsp_data, rsp_resp} !== 35'h0) $display("FAIL post_reset_rsp: got %h expected 0", {rsp_timeout, rsp_data, rsp_resp});
      else n_pass++;
   endtask

   task automatic test_single_read;
      res_t r;
      run_read(32'hFFFF_FFFF, 3'd0, 32'h1234_5678, 2'b00, 0, 0, 0, 1'b0, r);
      n_checks++;
      if (r.ar_cyc !== 1 || r.ar_bad) $display("FAIL single_ar: got %0d cycles bad=%0d expected 1 cycles bad=0", r.ar_cyc, r.ar_bad);
      else n_pass++;
      n_checks++;
      if (r.lat !== 3) $display("FAIL single_latency: got %0d expected 3", r.lat);
      else n_pass++;
      n_checks++;
      if (r.data !== 32'h1234_5678 || r.resp !== 2'b00) $display("FAIL single_rsp: got %h/%b expected 12345678/00", r.data, r.resp);
      else n_pass++;
      n_checks++;
      if (r.to !== 1'b0 || r.timed_out || r.rr_bad) $display("FAIL single_flags: got to=%b tmo=%0d rr=%0d expected 0", r.to, r.timed_out, r.rr_bad);
      else n_pass++;
   endtask

   task automatic test_ar_backpressure;
      res_t r;
      run_read(32'hF0F0_F0F0, 3'd3, 32'h0BAD_CAFE, 2'b01, 5, 0, 0, 1'b1, r);
      n_checks++;
      if (r.ar_cyc !== 6 || r.ar_bad) $display("FAIL arbp_hold: got %0d cycles bad=%0d expected 6 cycles bad=0", r.ar_cyc, r.ar_bad);
      else n_pass++;
      n_checks++;
      if (r.rr_bad) $display("FAIL arbp_rready: got early/late rready expected clean");
      else n_pass++;
      n_checks++;
      if (r.lat !== 8 || r.data !== 32'h0BAD_CAFE) $display("FAIL arbp_rsp: got lat=%0d %h expected lat=8 0badcafe", r.lat, r.data);
      else n_pass++;
   endtask

   task automatic test_rsp_backpressure;
      res_t r;
      run_read(32'h0000_1000, 3'd1, 32'hDEAD_BEEF, 2'b10, 0, 1, 3, 1'b1, r);
      n_checks++;
      if (r.rsp_bad) $display("FAIL rspbp_stable: got unstable rsp_* expected stable");
      else n_pass++;
      n_checks++;
      if (r.busy_ready) $display("FAIL rspbp_cmd_ready: got 1 while busy expected 0");
      else n_pass++;
      n_checks++;
      if (r.data !== 32'hDEAD_BEEF || r.resp !== 2'b10) $display("FAIL rspbp_rsp: got %h/%b expected deadbeef/10", r.data, r.resp);
      else n_pass++;
      n_checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rspbp_idle: got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      res_t r;
      int   prev;
      logic [31:0] d;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         run_read(32'h100 * i, 3'(i), d, 2'(i), 0, 0, 0, 1'b0, r);
         if (i > 0) begin
            n_checks++;
            if (r.hs_c - prev !== 4) $display("FAIL b2b_rate: got %0d cycles expected 4", r.hs_c - prev);
            else n_pass++;
         end
         prev = r.hs_c;
         n_checks++;
         if (r.data !== d || r.resp !== 2'(i)) $display("FAIL b2b_rsp: got %h/%b expected %h/%b", r.data, r.resp, d, 2'(i));
         else n_pass++;
      end
   endtask

   task automatic test_random;
      res_t        r;
      logic [31:0] addr, data, e_data;
      logic [2:0]  prot;
      logic [1:0]  resp, e_resp;
      logic        e_to;
      int          aw, rw, pw, e_lat;
      for (int i = 0; i < 20; i++) begin
         addr = $urandom;
         data = $urandom;
         prot = 3'($urandom);
         resp = 2'($urandom);
         aw   = $urandom_range(0, 4);
         rw   = $urandom_range(0, R_MAX);
         pw   = $urandom_range(0, 3);
         model(data, resp, aw, rw, e_data, e_resp, e_to, e_lat);
         run_read(addr, prot, data, resp, aw, rw, pw, 1'b1, r);
         n_checks++;
         if (r.data !== e_data) $display("FAIL rand_data[%0d]: got %h expected %h", i, r.data, e_data);
         else n_pass++;
         n_checks++;
         if (r.resp !== e_resp || r.to !== e_to) $display("FAIL rand_resp[%0d]: got %b/%b expected %b/%b", i, r.resp, r.to, e_resp, e_to);
         else n_pass++;
         n_checks++;
         if (r.lat !== e_lat) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, r.lat, e_lat);
         else n_pass++;
         n_checks++;
         if (r.ar_cyc !== aw + 1) $display("FAIL rand_ar_cycles[%0d]: got %0d expected %0d", i, r.ar_cyc, aw + 1);
         else n_pass++;
         n_checks++;
         if ({r.ar_bad, r.rr_bad, r.rsp_bad, r.busy_ready, r.timed_out} !== 5'b0)
            $display("FAIL rand_protocol[%0d]: got ar=%0d rr=%0d rsp=%0d busy=%0d tmo=%0d expected all 0",
                     i, r.ar_bad, r.rr_bad, r.rsp_bad, r.busy_ready, r.timed_out);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid;
      res_t r;
      int   guard;
      guard     = 0;
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0BAD_F00D;
      cmd_prot  = 3'd5;
      arready   = 1'b1;
      rvalid    = 1'b0;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      while (!rready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      arready = 1'b0;
      n_checks++;
      if (rready !== 1'b1) $display("FAIL mid_reach_data: got rready=%b expected 1", rready);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({arvalid, rready, rsp_valid, rsp_timeout, araddr, arprot, rsp_data, rsp_resp} !== 73'h0)
         $display("FAIL mid_reset_outputs: got %h expected 0",
                  {arvalid, rready, rsp_valid, rsp_timeout, araddr, arprot, rsp_data, rsp_resp});
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || rready !== 1'b0 || arvalid !== 1'b0) $display("FAIL mid_after_release: got ready=%b rready=%b arvalid=%b expected 1/0/0", cmd_ready, rready, arvalid);
      else n_pass++;
      run_read(32'h2468_ACE0, 3'd7, 32'h5A5A_0F0F, 2'b11, 0, 0, 0, 1'b0, r);
      n_checks++;
      if (r.data !== 32'h5A5A_0F0F || r.resp !== 2'b11 || r.lat !== 3) $display("FAIL mid_next_read: got %h/%b lat=%0d expected 5a5a0f0f/11 lat=3", r.data, r.resp, r.lat);
      else n_pass++;
   endtask

`ifdef MAXIL_READ_TIMEOUT_EN
   task automatic test_timeout;
      res_t r;
      run_read(32'h1357_9BDF, 3'd2, 32'h0, 2'b00, 0, 1000, 1, 1'b0, r);
      n_checks++;
      if (r.lat !== 2 + TO || r.timed_out) $display("FAIL to_latency: got %0d tmo=%0d expected %0d", r.lat, r.timed_out, 2 + TO);
      else n_pass++;
      n_checks++;
      if (r.data !== 32'h0 || r.resp !== 2'b10 || r.to !== 1'b1) $display("FAIL to_rsp: got %h/%b/%b expected 0/10/1", r.data, r.resp, r.to);
      else n_pass++;
      n_checks++;
      if (cmd_ready !== 1'b0 || rready !== 1'b1) $display("FAIL to_flush_wait: got ready=%b rready=%b expected 0/1", cmd_ready, rready);
      else n_pass++;
      rvalid = 1'b1;
      rdata  = 32'hAAAA_AAAA;
      rresp  = 2'b00;
      @(posedge clk);
      @(negedge clk);
      rvalid = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b1 || rready !== 1'b0) $display("FAIL to_flush_done: got ready=%b rready=%b expected 1/0", cmd_ready, rready);
      else n_pass++;
      run_read(32'h0000_0040, 3'd0, 32'h600D_CAFE, 2'b01, 1, 2, 0, 1'b0, r);
      n_checks++;
      if (r.data !== 32'h600D_CAFE || r.resp !== 2'b01 || r.to !== 1'b0) $display("FAIL to_next_read: got %h/%b/%b expected 600dcafe/01/0", r.data, r.resp, r.to);
      else n_pass++;
      run_read(32'h0000_0080, 3'd4, 32'h7777_1111, 2'b00, 0, TO - 1, 0, 1'b0, r);
      n_checks++;
      if (r.data !== 32'h7777_1111 || r.to !== 1'b0 || r.lat !== 2 + TO) $display("FAIL to_terminal_beat: got %h to=%b lat=%0d expected 77771111 to=0 lat=%0d", r.data, r.to, r.lat, 2 + TO);
      else n_pass++;
   endtask
`endif

   initial begin
      #500us;
      $display("FAIL watchdog: simulation stuck, got %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      cyc_count = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_prot  = '0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rdata     = '0;
      rresp     = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single_read();
      test_ar_backpressure();
      test_rsp_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef MAXIL_READ_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/maxil_read_top.md
Name: maxil_read_top

Overview:
- AXI4-Lite master read engine; sits directly upstream of the AXI-Lite slave read block and drives its AR channel and consumes its R channel.
- Accepts single-word read commands on a simple valid/ready command port.
- Issues one AR transaction per command and returns the data and response on a valid/ready response port.
- One outstanding transaction at a time; all AXI outputs are registered.

Parameters:
- ADDR_WIDTH, 32, AR address width and command address width.
- DATA_WIDTH, 32, R data width and response data width.
- TIMEOUT_CYCLES, 256, R-phase watchdog limit in clock cycles (used only with the optional feature); minimum 2.

Ports:
- maxil_read_top_clk  in  1  single clock; all state changes on rising edge
- maxil_read_top_rst_n  in  1  asynchronous active-low reset
- maxil_read_cmd_valid  in  1  command present
- maxil_read_cmd_ready  out  1  engine can accept a command
- maxil_read_cmd_addr  in  ADDR_WIDTH  read address
- maxil_read_cmd_prot  in  3  protection bits for AR
- maxil_read_arvalid  out  1  AR valid
- maxil_read_arready  in  1  AR ready from slave
- maxil_read_araddr  out  ADDR_WIDTH  AR address
- maxil_read_arprot  out  3  AR protection
- maxil_read_rvalid  in  1  R valid from slave
- maxil_read_rready  out  1  R ready
- maxil_read_rdata  in  DATA_WIDTH  R data
- maxil_read_rresp  in  2  R response
- maxil_read_rsp_valid  out  1  response present
- maxil_read_rsp_ready  in  1  consumer accepts response
- maxil_read_rsp_data  out  DATA_WIDTH  captured read data
- maxil_read_rsp_resp  out  2  captured RRESP
- maxil_read_rsp_timeout  out  1  response was produced by the watchdog

Behaviour:
- States: IDLE, ADDR, DATA, RSP. Reset state is IDLE.
- Reset values: arvalid=0, araddr=0, arprot=0, rready=0, rsp_valid=0, rsp_data=0, rsp_resp=0, rsp_timeout=0.
- cmd_ready = (state==IDLE), combinational; it is 1 during reset, but no handshake is sampled while rst_n=0.
- Reset asserted mid-transaction aborts immediately to IDLE with all outputs at their reset values. A pending slave R beat is not tracked across reset.
- IDLE: on cmd_valid&&cmd_ready, register addr/prot into araddr/arprot, set arvalid=1, go to ADDR.
- ADDR: arvalid stays high and araddr/arprot stay stable until arready. There is no timeout in ADDR (AXI forbids withdrawing arvalid). On arready: arvalid=0, rready=1, go to DATA.
- DATA: rready=1. On rvalid: capture rdata/rresp into rsp_data/rsp_resp, rsp_timeout=0, rready=0, rsp_valid=1, go to RSP.
- RSP: rsp_valid and all rsp_* outputs are held stable until rsp_ready. On rsp_ready: rsp_valid=0, go to IDLE.
- rvalid is ignored outside DATA, except for the flush case in the optional feature.
- Latency with arready and rvalid tied high:
  - command handshake at edge N;
  - arvalid high in cycle N+1;
  - rready high in cycle N+2;
  - rsp_valid high in cycle N+3.
  - Back-to-back commands: one every 4 cycles when rsp_ready is tied high.
- cmd_valid asserted in a non-IDLE state is not accepted; the command is held by the upstream side.
- rresp values 2'b10 and 2'b11 are passed through unchanged; no retry is performed.

Optional Feature:
- Macro: MAXIL_READ_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to DATA and increments each cycle in DATA without rvalid.
  - When the count reaches TIMEOUT_CYCLES-1 with no rvalid: rready=0, rsp_data=0, rsp_resp=2'b10, rsp_timeout=1, rsp_valid=1, go to RSP.
  - A sticky flush flag is then set. While it is set, rready=1 in IDLE and RSP, and ADDR entry is blocked (cmd_ready=0).
  - The first R beat seen while the flag is set is discarded and clears the flag.
  - rvalid arriving on the same cycle as the timeout terminal count is treated as a normal completion; no timeout is raised.
- Disabled: no counter or flag; rsp_timeout is tied to 0; DATA waits indefinitely.

Test Plan:
- Reset: rst_n low 5-20 ns -> arvalid=0, rready=0, rsp_valid=0, araddr=0; cmd_ready=1 after release.
- Single read: cmd addr=32'hFFFF_FFFF, prot=0; arready=1; rvalid=1 one cycle later with rdata=32'h1234_5678, rresp=0 -> araddr=FFFF_FFFF for exactly 1 cycle; rsp_valid=1, rsp_data=32'h1234_5678, rsp_resp=0 at N+3.
- AR backpressure: cmd addr=32'hF0F0_F0F0, arready low 5 cycles -> arvalid and araddr held stable for 6 cycles; rready stays 0 until the AR handshake.
- Response backpressure and SLVERR: rresp=2'b10, rdata=32'hDEAD_BEEF, rsp_ready low 3 cycles -> rsp_* stable; cmd_ready=0 until the rsp handshake; then IDLE.
- Reset mid-DATA: assert rst_n low while rready=1 -> all outputs return to reset values asynchronously; state is IDLE after release.
- With MAXIL_READ_TIMEOUT_EN, TIMEOUT_CYCLES=8, rvalid never asserted:
  - rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1 after 8 DATA cycles.
  - A late rvalid with rdata=32'hAAAA_AAAA is discarded, and the next command returns its own data.
